// File: rtl/master_cmd_queue.sv
// -----------------------------------------------------------------------------
// master_cmd_queue
//
// Purpose:
//   Buffers host commands (read/write plus address, slave select, data and
//   burst count) in a small FIFO. A four-state controller issues them one at a
//   time to a bus master port. Each issue is a single-cycle read or write
//   strobe. The controller then waits for the master to raise busy and drop it
//   again before it issues the next command.
//
// Optional feature:
//   MASTER_CMD_QUEUE_TIMEOUT_EN - when defined, a 4-bit counter runs while the
//   controller waits for busy to rise. If busy stays low for 15 cycles, the
//   command is dropped, the controller returns to idle and the sticky err_o
//   flag is set. When undefined, the controller waits indefinitely and err_o
//   is tied low.
//
// Ports:
//   clock_i        single clock, rising-edge active
//   rst_ni         asynchronous active-low reset
//   enable_i       permits starting a new command (in-flight ones complete)
//   cmd_valid_i    host offers a command this cycle
//   cmd_ready_o    queue can accept a command (not full)
//   cmd_write_i    1 = write, 0 = read
//   cmd_data_i     write data            [WORD_SIZE-1:0]
//   cmd_address_i  address               [ADDRESS_LEN-1:0]
//   cmd_slave_i    slave select          [SLAVE_LEN-1:0]
//   cmd_burst_i    burst count           [BURST_SIZE:0]
//   read_o         one-cycle read strobe to the master port
//   write_o        one-cycle write strobe to the master port
//   data_o         last issued data
//   address_o      last issued address
//   slave_o        last issued slave select
//   burst_num_o    last issued burst count
//   busy_i         master port busy indication
//   count_o        number of queued entries [clog2(DEPTH):0]
//   empty_o        queue empty
//   full_o         queue full
//   err_o          sticky acknowledge-timeout flag
// -----------------------------------------------------------------------------
module master_cmd_queue #(
    parameter int SLAVE_LEN   = 2,
    parameter int ADDRESS_LEN = 12,
    parameter int WORD_SIZE   = 8,
    parameter int BURST_SIZE  = 12,
    parameter int DEPTH       = 4
) (
    input  logic                     clock_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic                     cmd_write_i,
    input  logic [WORD_SIZE-1:0]     cmd_data_i,
    input  logic [ADDRESS_LEN-1:0]   cmd_address_i,
    input  logic [SLAVE_LEN-1:0]     cmd_slave_i,
    input  logic [BURST_SIZE:0]      cmd_burst_i,
    output logic                     read_o,
    output logic                     write_o,
    output logic [WORD_SIZE-1:0]     data_o,
    output logic [ADDRESS_LEN-1:0]   address_o,
    output logic [SLAVE_LEN-1:0]     slave_o,
    output logic [BURST_SIZE:0]      burst_num_o,
    input  logic                     busy_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic                     err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    // All fields of one command travel together through the queue.
    typedef struct packed {
        logic                   is_write;
        logic [WORD_SIZE-1:0]   data;
        logic [ADDRESS_LEN-1:0] address;
        logic [SLAVE_LEN-1:0]   slave;
        logic [BURST_SIZE:0]    burst;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE
    } state_e;

    // -------------------------------------------------------------------------
    // Queue storage and bookkeeping
    // -------------------------------------------------------------------------
    entry_t             mem_q [DEPTH];
    entry_t             entry_in;
    entry_t             head_entry;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q,  count_d;

    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    state_e             state_q, state_d;
    logic               load_issue;

    // Issue-side registers: fields hold the last issued command.
    logic                   read_q,  read_d;
    logic                   write_q, write_d;
    logic [WORD_SIZE-1:0]   data_q,  data_d;
    logic [ADDRESS_LEN-1:0] addr_q,  addr_d;
    logic [SLAVE_LEN-1:0]   slave_q, slave_d;
    logic [BURST_SIZE:0]    burst_q, burst_d;

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);

    // A push while full is refused by holding cmd_ready_o low.
    assign push = cmd_valid_i && !full;
    // The head entry leaves the queue during the single ISSUE cycle.
    assign pop  = (state_q == ST_ISSUE);

    assign entry_in = '{
        is_write: cmd_write_i,
        data:     cmd_data_i,
        address:  cmd_address_i,
        slave:    cmd_slave_i,
        burst:    cmd_burst_i
    };

    assign head_entry = mem_q[rd_ptr_q];

    // Storage is not reset. The pointers and count define which entries are
    // valid, so stale contents are never observed.
    always_ff @(posedge clock_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry_in;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointer wrap is natural overflow.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // Acknowledge timeout (optional)
    // -------------------------------------------------------------------------
`ifdef MASTER_CMD_QUEUE_TIMEOUT_EN
    // The counter reads 0 in the first WAIT_ACK cycle and 14 in the fifteenth.
    // It is checked in that fifteenth cycle.
    localparam logic [3:0] ACK_LAST = 4'd14;

    logic [3:0] ack_cnt_q, ack_cnt_d;
    logic       err_q,     err_d;
    logic       ack_timeout;

    always_comb begin
        ack_cnt_d = (state_q == ST_WAIT_ACK) ? (ack_cnt_q + 4'd1) : 4'd0;
        err_d     = err_q | ack_timeout;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Issue controller: next state and issue-register loading
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        load_issue = 1'b0;
`ifdef MASTER_CMD_QUEUE_TIMEOUT_EN
        ack_timeout = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // enable_i gates only this transition. A command already
                // issued always runs to completion.
                if (enable_i && !empty && !busy_i) begin
                    state_d    = ST_ISSUE;
                    load_issue = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (busy_i) begin
                    state_d = ST_WAIT_DONE;
                end
`ifdef MASTER_CMD_QUEUE_TIMEOUT_EN
                else if (ack_cnt_q == ACK_LAST) begin
                    state_d     = ST_IDLE;
                    ack_timeout = 1'b1;
                end
`endif
            end
            ST_WAIT_DONE: begin
                if (!busy_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes and fields are registered. They are loaded on the edge that
    // enters ISSUE, so they become visible exactly during the ISSUE cycle.
    // The head is stable on that edge because nothing pops in IDLE.
    always_comb begin
        read_d  = 1'b0;
        write_d = 1'b0;
        data_d  = data_q;
        addr_d  = addr_q;
        slave_d = slave_q;
        burst_d = burst_q;
        if (load_issue) begin
            read_d  = !head_entry.is_write;
            write_d = head_entry.is_write;
            data_d  = head_entry.data;
            addr_d  = head_entry.address;
            slave_d = head_entry.slave;
            burst_d = head_entry.burst;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            data_q   <= '0;
            addr_q   <= '0;
            slave_q  <= '0;
            burst_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            read_q   <= read_d;
            write_q  <= write_d;
            data_q   <= data_d;
            addr_q   <= addr_d;
            slave_q  <= slave_d;
            burst_q  <= burst_d;
        end
    end

`ifdef MASTER_CMD_QUEUE_TIMEOUT_EN
    always_ff @(posedge clock_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_cnt_q <= 4'd0;
            err_q     <= 1'b0;
        end else begin
            ack_cnt_q <= ack_cnt_d;
            err_q     <= err_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign cmd_ready_o = !full;
    assign count_o     = count_q;
    assign empty_o     = empty;
    assign full_o      = full;
    assign read_o      = read_q;
    assign write_o     = write_q;
    assign data_o      = data_q;
    assign address_o   = addr_q;
    assign slave_o     = slave_q;
    assign burst_num_o = burst_q;

endmodule

// File: tb/tb_master_cmd_queue.sv
// -----------------------------------------------------------------------------
// tb_master_cmd_queue
//
// Self-checking bench for master_cmd_queue. A behavioural reference keeps a
// queue of accepted commands and a protocol phase derived from the issue rules.
// Every cycle, each DUT output is compared against that reference. Directed
// scenarios cover reset, ordering, full, push-during-issue, reset mid-command
// and (with MASTER_CMD_QUEUE_TIMEOUT_EN) the acknowledge timeout. They are
// followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_master_cmd_queue;

    localparam int SLAVE_LEN   = 2;
    localparam int ADDRESS_LEN = 12;
    localparam int WORD_SIZE   = 8;
    localparam int BURST_SIZE  = 12;
    localparam int DEPTH       = 4;

`ifdef MASTER_CMD_QUEUE_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    // Busy stimulus styles
    localparam int BM_RAND = 0;   // random busy every cycle
    localparam int BM_RESP = 1;   // busy high 2..6 cycles after each strobe
    localparam int BM_LOW  = 2;   // busy held low

    // Reference protocol phases
    localparam int P_IDLE  = 0;
    localparam int P_ISSUE = 1;
    localparam int P_WACK  = 2;
    localparam int P_WDONE = 3;

    typedef struct packed {
        logic                   w;
        logic [WORD_SIZE-1:0]   d;
        logic [ADDRESS_LEN-1:0] a;
        logic [SLAVE_LEN-1:0]   s;
        logic [BURST_SIZE:0]    b;
    } cmd_t;

    logic                     clock_i = 1'b0;
    logic                     rst_ni  = 1'b0;
    logic                     enable_i = 1'b0;
    logic                     cmd_valid_i = 1'b0;
    logic                     cmd_ready_o;
    logic                     cmd_write_i = 1'b0;
    logic [WORD_SIZE-1:0]     cmd_data_i = '0;
    logic [ADDRESS_LEN-1:0]   cmd_address_i = '0;
    logic [SLAVE_LEN-1:0]     cmd_slave_i = '0;
    logic [BURST_SIZE:0]      cmd_burst_i = '0;
    logic                     read_o;
    logic                     write_o;
    logic [WORD_SIZE-1:0]     data_o;
    logic [ADDRESS_LEN-1:0]   address_o;
    logic [SLAVE_LEN-1:0]     slave_o;
    logic [BURST_SIZE:0]      burst_num_o;
    logic                     busy_i = 1'b0;
    logic [$clog2(DEPTH):0]   count_o;
    logic                     empty_o;
    logic                     full_o;
    logic                     err_o;

    master_cmd_queue #(
        .SLAVE_LEN  (SLAVE_LEN),
        .ADDRESS_LEN(ADDRESS_LEN),
        .WORD_SIZE  (WORD_SIZE),
        .BURST_SIZE (BURST_SIZE),
        .DEPTH      (DEPTH)
    ) dut (
        .clock_i      (clock_i),
        .rst_ni       (rst_ni),
        .enable_i     (enable_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_write_i  (cmd_write_i),
        .cmd_data_i   (cmd_data_i),
        .cmd_address_i(cmd_address_i),
        .cmd_slave_i  (cmd_slave_i),
        .cmd_burst_i  (cmd_burst_i),
        .read_o       (read_o),
        .write_o      (write_o),
        .data_o       (data_o),
        .address_o    (address_o),
        .slave_o      (slave_o),
        .burst_num_o  (burst_num_o),
        .busy_i       (busy_i),
        .count_o      (count_o),
        .empty_o      (empty_o),
        .full_o       (full_o),
        .err_o        (err_o)
    );

    always #5 clock_i = ~clock_i;

    // Counters and reference state
    int   checks_cnt   = 0;
    int   errors_cnt   = 0;
    int   n_issued     = 0;
    int   since_strobe = 1000;
    int   busy_mode    = BM_RESP;

    cmd_t mq[$];
    int   m_phase    = P_IDLE;
    cmd_t m_last     = '0;
    bit   m_err      = 1'b0;
    int   m_ack_wait = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic cmd_t cur_cmd();
        cmd_t c;
        c.w = cmd_write_i;
        c.d = cmd_data_i;
        c.a = cmd_address_i;
        c.s = cmd_slave_i;
        c.b = cmd_burst_i;
        return c;
    endfunction

    // Advance the reference across one rising edge, using the inputs that are
    // being driven into that edge.
    task automatic model_edge();
        int sz;
        bit push;
        sz   = mq.size();
        push = cmd_valid_i && (sz < DEPTH);
        case (m_phase)
            P_ISSUE: begin
                mq.delete(0);
                m_phase    = P_WACK;
                m_ack_wait = 0;
            end
            P_WACK: begin
                if (busy_i) begin
                    m_phase = P_WDONE;
                end else begin
                    m_ack_wait++;
                    if (TMO_EN && m_ack_wait == 15) begin
                        m_phase = P_IDLE;
                        m_err   = 1'b1;
                    end
                end
            end
            P_WDONE: begin
                if (!busy_i) m_phase = P_IDLE;
            end
            default: begin
                if (enable_i && sz > 0 && !busy_i) begin
                    m_phase = P_ISSUE;
                    m_last  = mq[0];
                end
            end
        endcase
        if (push) mq.push_back(cur_cmd());
    endtask

    task automatic compare_all();
        int sz;
        sz = mq.size();
        check_val("write",     write_o,     (m_phase == P_ISSUE) &&  m_last.w);
        check_val("read",      read_o,      (m_phase == P_ISSUE) && !m_last.w);
        check_val("data",      data_o,      m_last.d);
        check_val("address",   address_o,   m_last.a);
        check_val("slave",     slave_o,     m_last.s);
        check_val("burst_num", burst_num_o, m_last.b);
        check_val("count",     count_o,     sz);
        check_val("empty",     empty_o,     sz == 0);
        check_val("full",      full_o,      sz == DEPTH);
        check_val("cmd_ready", cmd_ready_o, sz != DEPTH);
        check_val("err",       err_o,       m_err);
    endtask

    // One clock cycle: reference update, edge, compare, transaction log, and
    // busy for the following cycle.
    task automatic tick();
        int nxt;
        model_edge();
        @(posedge clock_i);
        #1;
        compare_all();
        if (read_o || write_o) begin
            n_issued++;
            since_strobe = 0;
            $display("issue %0d %s slave=%0d addr=0x%03h data=0x%02h burst=%0d",
                     n_issued, write_o ? "WR" : "RD", slave_o, address_o, data_o, burst_num_o);
        end else if (since_strobe < 1000) begin
            since_strobe++;
        end
        nxt = since_strobe + 1;
        case (busy_mode)
            BM_RAND: busy_i = ($urandom_range(0, 99) < 35);
            BM_RESP: busy_i = (nxt >= 2 && nxt <= 6);
            default: busy_i = 1'b0;
        endcase
    endtask

    task automatic push_cmd(input bit w, input int d, input int a, input int s, input int b);
        cmd_write_i   = w;
        cmd_data_i    = WORD_SIZE'(d);
        cmd_address_i = ADDRESS_LEN'(a);
        cmd_slave_i   = SLAVE_LEN'(s);
        cmd_burst_i   = (BURST_SIZE + 1)'(b);
        cmd_valid_i   = 1'b1;
        tick();
        cmd_valid_i   = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Asynchronous reset, checked between clock edges.
    task automatic apply_reset();
        #2;
        rst_ni      = 1'b0;
        cmd_valid_i = 1'b0;
        #1;
        check_val("rst_count", count_o,     0);
        check_val("rst_empty", empty_o,     1);
        check_val("rst_full",  full_o,      0);
        check_val("rst_ready", cmd_ready_o, 1);
        check_val("rst_read",  read_o,      0);
        check_val("rst_write", write_o,     0);
        check_val("rst_data",  data_o,      0);
        check_val("rst_addr",  address_o,   0);
        check_val("rst_slave", slave_o,     0);
        check_val("rst_burst", burst_num_o, 0);
        check_val("rst_err",   err_o,       0);
        mq.delete();
        m_phase    = P_IDLE;
        m_last     = '0;
        m_err      = 1'b0;
        m_ack_wait = 0;
        @(posedge clock_i);
        #1;
        @(posedge clock_i);
        #1;
        rst_ni       = 1'b1;
        busy_i       = 1'b0;
        since_strobe = 1000;
    endtask

    initial begin
        int base;
        bit found;

        apply_reset();

        // Reset release: the first push is accepted on the next edge and
        // issues two edges later.
        enable_i  = 1'b1;
        busy_mode = BM_RESP;
        push_cmd(1'b1, 120, 0, 0, 0);
        tick();
        check_val("first_write", write_o, 1);
        check_val("first_data",  data_o,  120);
        tick();
        check_val("first_count", count_o, 0);
        check_val("first_empty", empty_o, 1);
        run(12);

        // Ordering: three commands, issued in push order.
        base = n_issued;
        push_cmd(1'b0, 8'h00, 12'h010, 1, 3);
        push_cmd(1'b1, 8'hAB, 12'h020, 2, 7);
        push_cmd(1'b0, 8'h00, 12'h030, 3, 1);
        run(40);
        check_val("order_issued", n_issued - base, 3);

        // Full: DEPTH+1 pushes with issuing disabled.
        enable_i = 1'b0;
        base     = n_issued;
        for (int i = 0; i < DEPTH; i++) push_cmd(i[0], 16 + i, 12'h100 + i, i % 4, i);
        check_val("full_flag",  full_o,      1);
        check_val("full_ready", cmd_ready_o, 0);
        check_val("full_count", count_o,     DEPTH);
        push_cmd(1'b1, 8'hEE, 12'hEEE, 3, 99);
        enable_i = 1'b1;
        run(60);
        check_val("full_drained", n_issued - base, DEPTH);

        // Push during the ISSUE cycle with one entry queued.
        enable_i = 1'b0;
        push_cmd(1'b0, 8'h11, 12'h0A1, 1, 2);
        enable_i = 1'b1;
        found    = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = read_o || write_o;
        end
        check_val("pp_strobe_seen", found, 1);
        push_cmd(1'b1, 8'h5C, 12'h0A2, 2, 4);
        check_val("pp_count", count_o, 1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = read_o || write_o;
        end
        check_val("pp_next_seen", found, 1);
        check_val("pp_next_data", data_o, 8'h5C);
        run(12);

        // Reset while waiting for busy to fall, with two entries still queued.
        enable_i = 1'b0;
        for (int i = 0; i < 3; i++) push_cmd(1'b1, 8'h70 + i, 12'h300 + i, 0, 1);
        enable_i = 1'b1;
        for (int i = 0; i < 30 && m_phase != P_WDONE; i++) tick();
        check_val("mid_in_wdone", m_phase == P_WDONE, 1);
        check_val("mid_queued",   count_o, 2);
        apply_reset();
        check_val("mid_empty", empty_o, 1);
        base = n_issued;
        run(15);
        check_val("mid_no_issue", n_issued - base, 0);

`ifdef MASTER_CMD_QUEUE_TIMEOUT_EN
        // Acknowledge timeout: busy never rises after the strobe.
        busy_mode = BM_LOW;
        busy_i    = 1'b0;
        enable_i  = 1'b0;
        push_cmd(1'b1, 8'hC1, 12'h401, 1, 5);
        push_cmd(1'b0, 8'hC2, 12'h402, 2, 6);
        enable_i = 1'b1;
        found    = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = read_o || write_o;
        end
        check_val("tmo_strobe_seen", found, 1);
        run(15);
        check_val("tmo_err_early", err_o, 0);
        tick();
        check_val("tmo_err_set", err_o, 1);
        tick();
        check_val("tmo_next_read", read_o, 1);
        check_val("tmo_next_addr", address_o, 12'h402);
        busy_mode = BM_RESP;
        run(30);
        check_val("tmo_err_sticky", err_o, 1);
        apply_reset();
`endif

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) busy_mode = (busy_mode == BM_RAND) ? BM_RESP : BM_RAND;
            enable_i      = ($urandom_range(0, 99) < 90);
            cmd_valid_i   = ($urandom_range(0, 99) < 55);
            cmd_write_i   = 1'($urandom_range(0, 1));
            cmd_data_i    = WORD_SIZE'($urandom);
            cmd_address_i = ADDRESS_LEN'($urandom);
            cmd_slave_i   = SLAVE_LEN'($urandom);
            cmd_burst_i   = (BURST_SIZE + 1)'($urandom);
            tick();
            if ($urandom_range(0, 399) == 0) apply_reset();
        end
        cmd_valid_i = 1'b0;
        busy_mode   = BM_RESP;
        run(60);
        check_val("final_empty", empty_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

    // Absolute guard against a stuck run.
    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
